// File: rtl/ray_issue_arbiter.sv
// Ray issue arbiter: shares the generator's primary and reflection slots
// between NUM_SRC producers with per-class round robin and credit limiting.
module ray_issue_arbiter #(
    parameter int DATA_W       = 256,
    parameter int NUM_SRC      = 4,
    parameter int MAX_INFLIGHT = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_SRC-1:0]                src_valid,
    input  logic [NUM_SRC-1:0]                src_is_ref,
    input  logic [NUM_SRC*DATA_W-1:0]         src_data,
    output logic [NUM_SRC-1:0]                src_ready,
    output logic                              gen_add,
    output logic [DATA_W-1:0]                 gen_data,
    input  logic                              gen_full,
    output logic                              gen_add_ref,
    output logic [DATA_W-1:0]                 gen_ref_data,
    input  logic                              gen_ref_full,
    input  logic                              ray_retire,
    input  logic                              drain,
    output logic                              idle,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              retire_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int IW = $clog2(NUM_SRC);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_p_q, ptr_p_d, ptr_r_q, ptr_r_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     credits;
    logic              add_p_q, add_r_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_p_q, data_p_d, data_r_q, data_r_d;
    logic              found_p, found_r;
    logic [IW-1:0]     win_p, win_r;
    logic              run_ok, cand_p, cand_r;
    logic              grant_p, grant_r, ret_ok;
    int                ip, ir;

    // Round-robin search per class, starting after the last granted source
    always_comb begin
        found_p = 1'b0;
        found_r = 1'b0;
        win_p   = '0;
        win_r   = '0;
        ip      = 0;
        ir      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            ip = (int'(ptr_p_q) + k) % NUM_SRC;
            ir = (int'(ptr_r_q) + k) % NUM_SRC;
            if (!found_p && src_valid[ip] && !src_is_ref[ip]) begin
                found_p = 1'b1;
                win_p   = IW'(ip);
            end
            if (!found_r && src_valid[ir] && src_is_ref[ir]) begin
                found_r = 1'b1;
                win_r   = IW'(ir);
            end
        end
    end

    // Credit check and primary anti-starvation decide which candidates issue
    always_comb begin
        credits  = CW'(MAX_INFLIGHT) - inflight_q;
        run_ok   = resetn && (state_q == RUN) && !drain;
        cand_p   = run_ok && found_p && !(gen_full || add_p_q);
        cand_r   = run_ok && found_r && !(gen_ref_full || add_r_q);
        grant_p  = 1'b0;
        grant_r  = 1'b0;
        starve_d = starve_q;
        if (credits >= CW'(2)) begin
            grant_p = cand_p;
            grant_r = cand_r;
        end else if (credits == CW'(1)) begin
            if (cand_p && cand_r) begin
                if (starve_q == SW'(STARVE_LIMIT)) grant_p = 1'b1;
                else                               grant_r = 1'b1;
            end else begin
                grant_p = cand_p;
                grant_r = cand_r;
            end
        end
        if (grant_p) begin
            starve_d = '0;
        end else if (cand_p && grant_r &&
                     starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Grant vector, issue payloads, pointers and the outstanding count
    always_comb begin
        src_ready = '0;
        if (grant_p) src_ready[win_p] = 1'b1;
        if (grant_r) src_ready[win_r] = 1'b1;
        ptr_p_d  = grant_p ? win_p : ptr_p_q;
        ptr_r_d  = grant_r ? win_r : ptr_r_q;
        data_p_d = grant_p ? src_data[int'(win_p)*DATA_W +: DATA_W]
                           : data_p_q;
        data_r_d = grant_r ? src_data[int'(win_r)*DATA_W +: DATA_W]
                           : data_r_q;
        ret_ok     = ray_retire && (inflight_q != '0);
        inflight_d = inflight_q + CW'(grant_p) + CW'(grant_r)
                   - CW'(ret_ok);
        err_d      = err_q | (ray_retire & (inflight_q == '0));
    end

    // Drain sequencing: stop granting, then wait for every ray to retire
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain) state_d = DRAIN;
            DRAIN: begin
                if (!drain)                 state_d = RUN;
                else if (inflight_d == '0) state_d = DONE;
            end
            DONE:    if (!drain) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State registers; pointers reset to the last index so source 0 goes first
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            ptr_p_q    <= IW'(NUM_SRC - 1);
            ptr_r_q    <= IW'(NUM_SRC - 1);
            starve_q   <= '0;
            inflight_q <= '0;
            add_p_q    <= 1'b0;
            add_r_q    <= 1'b0;
            data_p_q   <= '0;
            data_r_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_p_q    <= ptr_p_d;
            ptr_r_q    <= ptr_r_d;
            starve_q   <= starve_d;
            inflight_q <= inflight_d;
            add_p_q    <= grant_p;
            add_r_q    <= grant_r;
            data_p_q   <= data_p_d;
            data_r_q   <= data_r_d;
            err_q      <= err_d;
        end
    end

    assign gen_add      = add_p_q;
    assign gen_add_ref  = add_r_q;
    assign gen_data     = data_p_q;
    assign gen_ref_data = data_r_q;
    assign idle         = (state_q == DONE);
    assign inflight     = inflight_q;
    assign retire_err   = err_q;

endmodule

// File: tb/tb_ray_issue_arbiter.sv
// Bench for ray_issue_arbiter: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_ray_issue_arbiter;

    localparam int DW   = 256;
    localparam int NS   = 4;
    localparam int MAXI = 16;
    localparam int LIM  = 8;
    localparam int CW   = $clog2(MAXI + 1);

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS-1:0]     src_is_ref = '0;
    logic [NS*DW-1:0]  src_data = '0;
    logic [NS-1:0]     src_ready;
    logic              gen_add, gen_add_ref;
    logic [DW-1:0]     gen_data, gen_ref_data;
    logic              gen_full = 1'b0, gen_ref_full = 1'b0;
    logic              ray_retire = 1'b0, drain = 1'b0;
    logic              idle, retire_err;
    logic [CW-1:0]     inflight;

    ray_issue_arbiter #(
        .DATA_W(DW), .NUM_SRC(NS), .MAX_INFLIGHT(MAXI), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_is_ref(src_is_ref),
        .src_data(src_data), .src_ready(src_ready),
        .gen_add(gen_add), .gen_data(gen_data), .gen_full(gen_full),
        .gen_add_ref(gen_add_ref), .gen_ref_data(gen_ref_data),
        .gen_ref_full(gen_ref_full), .ray_retire(ray_retire),
        .drain(drain), .idle(idle), .inflight(inflight),
        .retire_err(retire_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: 0 run, 1 drain, 2 done
    int          m_inf, m_lastp, m_lastr, m_starve, m_state;
    bit          m_addp, m_addr, m_err;
    logic [DW-1:0] m_dp, m_dr;
    bit          e_gp, e_gr, e_cp;
    int          e_wp, e_wr;
    logic [NS-1:0] e_ready;

    logic [NS-1:0] obs_ready;
    int          obs_adds;
    int          ng, refw, primw;
    logic [NS-1:0] seq [0:7];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_inf = 0; m_lastp = NS - 1; m_lastr = NS - 1;
        m_starve = 0; m_state = 0;
        m_addp = 0; m_addr = 0; m_err = 0;
        m_dp = '0; m_dr = '0;
    endtask

    function automatic int pick(input int last, input bit want_ref);
        for (int k = 1; k <= NS; k++) begin
            int i;
            i = (last + k) % NS;
            if (src_valid[i] && (src_is_ref[i] == want_ref)) return i;
        end
        return -1;
    endfunction

    task automatic compute_exp();
        int cred;
        bit ok, cr;
        e_wp = pick(m_lastp, 1'b0);
        e_wr = pick(m_lastr, 1'b1);
        ok   = resetn && (m_state == 0) && !drain;
        e_cp = ok && (e_wp >= 0) && !gen_full && !m_addp;
        cr   = ok && (e_wr >= 0) && !gen_ref_full && !m_addr;
        cred = MAXI - m_inf;
        e_gp = 0; e_gr = 0;
        if (cred >= 2) begin
            e_gp = e_cp; e_gr = cr;
        end else if (cred == 1) begin
            if (e_cp && cr) begin
                if (m_starve == LIM) e_gp = 1; else e_gr = 1;
            end else begin
                e_gp = e_cp; e_gr = cr;
            end
        end
        e_ready = '0;
        if (e_gp) e_ready[e_wp] = 1'b1;
        if (e_gr) e_ready[e_wr] = 1'b1;
    endtask

    task automatic model_update();
        int ret;
        if (!resetn) begin
            m_reset();
            return;
        end
        ret = (ray_retire && m_inf > 0) ? 1 : 0;
        if (ray_retire && m_inf == 0) m_err = 1;
        if (e_gp) begin
            m_dp = src_data[e_wp*DW +: DW];
            m_lastp = e_wp;
            m_starve = 0;
        end else if (e_cp && e_gr && m_starve < LIM) begin
            m_starve++;
        end
        if (e_gr) begin
            m_dr = src_data[e_wr*DW +: DW];
            m_lastr = e_wr;
        end
        m_addp = e_gp;
        m_addr = e_gr;
        m_inf = m_inf + int'(e_gp) + int'(e_gr) - ret;
        case (m_state)
            0: if (drain) m_state = 1;
            1: if (!drain) m_state = 0;
               else if (m_inf == 0) m_state = 2;
            default: if (!drain) m_state = 0;
        endcase
    endtask

    task automatic check_all();
        compute_exp();
        chk("src_ready", src_ready, e_ready);
        chk("gen_add", gen_add, m_addp);
        chk("gen_add_ref", gen_add_ref, m_addr);
        chk("gen_data", gen_data, m_dp);
        chk("gen_ref_data", gen_ref_data, m_dr);
        chk("inflight", inflight, m_inf);
        chk("idle", idle, (m_state == 2));
        chk("retire_err", retire_err, m_err);
    endtask

    task automatic tick();
        #1;
        check_all();
        obs_ready = src_ready;
        obs_adds += int'(gen_add) + int'(gen_add_ref);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NS * DW / 32; i++)
            src_data[i*32 +: 32] = $urandom;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {src_ready, gen_add, gen_add_ref, idle,
                           retire_err, inflight}, 0);
        chk({nm, "_data"}, gen_data | gen_ref_data, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        src_valid = '0; drain = 0; ray_retire = 0;
        gen_full = 0; gen_ref_full = 0;
        #1;
        m_reset();
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        obs_adds = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset0");
        resetn = 1'b1;

        // round robin among four primary sources
        src_is_ref = '0; src_valid = '1; ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            rand_data();
            ray_retire = (m_inf > 0);
            tick();
            if (obs_ready != 0) begin
                seq[ng] = obs_ready;
                ng++;
            end
        end
        ray_retire = 0;
        chk("rr_count", ng, 8);
        for (int i = 0; i < ng; i++) chk("rr_order", seq[i], 1 << (i % 4));
        gen_full = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_block", obs_ready, 0);
        end
        gen_full = 0;

        // credit fill with two ref and two primary sources
        do_reset();
        src_valid = '1; src_is_ref = 4'b0011; obs_adds = 0;
        repeat (30) begin
            rand_data();
            tick();
        end
        chk("fill_adds", obs_adds, 16);
        chk("fill_inflight", inflight, 16);
        chk("fill_ready", src_ready, 0);
        ray_retire = 1;
        tick();
        ray_retire = 0;
        ng = 0; refw = 0; primw = 0;
        repeat (6) begin
            tick();
            if (obs_ready != 0) ng++;
            if ((obs_ready & 4'b0011) != 0) refw++;
            if ((obs_ready & 4'b1100) != 0) primw++;
        end
        chk("one_more", ng, 1);
        for (int i = 0; i < 20 && primw == 0; i++) begin
            ray_retire = 1;
            tick();
            ray_retire = 0;
            tick();
            if ((obs_ready & 4'b0011) != 0) refw++;
            if ((obs_ready & 4'b1100) != 0) primw++;
        end
        chk("starve_refwins", refw, 8);
        chk("starve_prim", primw, 1);
        ray_retire = 1;
        tick();
        ray_retire = 0;
        tick();
        chk("post_starve_ref", obs_ready, 4'b0001 << (m_lastr));

        // drain with five rays outstanding
        do_reset();
        src_is_ref = '0; src_valid = '1; ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            tick();
            if (obs_ready != 0) ng++;
        end
        chk("drain_pre", ng, 5);
        drain = 1; ng = 0;
        for (int r = 0; r < 5; r++) begin
            chk("idle_before", idle, 0);
            ray_retire = 1;
            tick();
            if (obs_ready != 0) ng++;
            ray_retire = 0;
            chk("idle_after", idle, (r == 4));
            repeat (2) begin
                tick();
                if (obs_ready != 0) ng++;
            end
        end
        chk("drain_nogrant", ng, 0);
        chk("drain_inflight", inflight, 0);
        drain = 0; ng = 0;
        for (int c = 0; c < 6 && ng == 0; c++) begin
            tick();
            if (obs_ready != 0) ng++;
        end
        chk("drain_resume", ng, 1);

        // retire with nothing outstanding
        do_reset();
        ray_retire = 1;
        tick();
        ray_retire = 0;
        chk("err_set", retire_err, 1);
        chk("err_inflight", inflight, 0);
        repeat (3) tick();
        chk("err_sticky", retire_err, 1);
        do_reset();
        chk("err_cleared", retire_err, 0);

        // reset in the middle of an issue
        src_is_ref = '0; src_valid = '1; ng = 0;
        for (int c = 0; c < 40 && ng < 7; c++) begin
            rand_data();
            tick();
            if (obs_ready != 0) ng++;
        end
        chk("mid_add", gen_add, 1);
        chk("mid_inflight", inflight, 7);
        resetn = 1'b0;
        src_valid = '0;
        #1;
        chk_zero("mid_reset");
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        src_valid = '1;
        tick();
        chk("post_rst_first", obs_ready, 4'b0001);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                src_valid = '0;
                src_is_ref = NS'($urandom);
            end else begin
                src_valid = NS'($urandom);
            end
            drain = ((c / 150) % 4 == 3) && ((c % 150) < 60);
            gen_full = ($urandom % 4 == 0);
            gen_ref_full = ($urandom % 4 == 0);
            ray_retire = ((m_inf > 0) && ($urandom % 2 == 0)) ||
                         ($urandom % 64 == 0);
            rand_data();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
